// File: rtl/local_history_table.sv
// local_history_table: per-branch local outcome histories with a post-reset clearing sweep and same-cycle read/write bypass
module local_history_table #(
   parameter int PC_IDX_W = 10,
   parameter int HIST_W   = 10
) (
   input  logic                clock,
   input  logic                reset_n,
   output logic                ready,
   input  logic                pred_valid,
   input  logic [PC_IDX_W-1:0] pred_pc,
   output logic                hist_valid,
   output logic [HIST_W-1:0]   hist_out,
   input  logic                upd_valid,
   input  logic [PC_IDX_W-1:0] upd_pc,
   input  logic                upd_taken
);
   localparam int DEPTH = 2**PC_IDX_W;
   typedef enum logic {INIT, RUN} state_t;
   state_t              state;
   logic [PC_IDX_W-1:0] init_ptr;
   logic [HIST_W-1:0]   hist_mem [DEPTH];
   logic [HIST_W-1:0]   upd_hist;
   assign upd_hist = {hist_mem[upd_pc][HIST_W-2:0], upd_taken};
   // table writes: clearing sweep while in INIT, newest outcome shifted into the LSB in RUN
   always_ff @(posedge clock) begin
      if (state == INIT) hist_mem[init_ptr] <= '0;
      else if (upd_valid) hist_mem[upd_pc] <= upd_hist;
   end
   // control FSM and registered lookup; a same-index update is forwarded to the lookup
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= INIT;
         init_ptr   <= '0;
         ready      <= 1'b0;
         hist_valid <= 1'b0;
         hist_out   <= '0;
      end else begin
         case (state)
            INIT: begin
               init_ptr   <= init_ptr + 1'b1;
               hist_valid <= 1'b0;
               if (init_ptr == '1) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               hist_valid <= pred_valid;
               if (pred_valid) hist_out <= (upd_valid && upd_pc == pred_pc) ? upd_hist : hist_mem[pred_pc];
            end
            default: state <= INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_local_history_table.sv
// tb_local_history_table: random and directed checks of local_history_table against a table-of-integers model
module tb_local_history_table;
   localparam int DEPTH = 1024;
   localparam int MASK  = 1023;
   logic       clock = 1'b0;
   logic       reset_n = 1'b1;
   logic       ready;
   logic       pred_valid = 1'b0;
   logic [9:0] pred_pc = '0;
   logic       hist_valid;
   logic [9:0] hist_out;
   logic       upd_valid = 1'b0;
   logic [9:0] upd_pc = '0;
   logic       upd_taken = 1'b0;
   int model [DEPTH];
   int init_left;
   int exp_out;
   int exp_valid;
   int n_checks = 0;
   int n_fail = 0;

   local_history_table dut (
      .clock(clock), .reset_n(reset_n), .ready(ready),
      .pred_valid(pred_valid), .pred_pc(pred_pc),
      .hist_valid(hist_valid), .hist_out(hist_out),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock: drive inputs, advance the model by the edge, compare all outputs
   task automatic cycle(input bit pv, input int pp, input bit uv, input int up, input bit ut);
      int nv;
      pred_valid = pv;
      pred_pc    = pp[9:0];
      upd_valid  = uv;
      upd_pc     = up[9:0];
      upd_taken  = ut;
      @(posedge clock);
      #1;
      if (init_left > 0) begin
         init_left--;
         exp_valid = 0;
      end else begin
         nv = ((model[up] * 2) + ut) & MASK;
         if (pv) exp_out = (uv && up == pp) ? nv : model[pp];
         exp_valid = pv;
         if (uv) model[up] = nv;
      end
      check("ready", ready, (init_left == 0) ? 1 : 0);
      check("hist_valid", hist_valid, exp_valid);
      check("hist_out", hist_out, exp_out);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_ready", ready, 0);
      check("rst_hist_valid", hist_valid, 0);
      check("rst_hist_out", hist_out, 0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      init_left = DEPTH;
      exp_out = 0;
      exp_valid = 0;
      for (int i = 0; i < DEPTH; i++) model[i] = 0;
   endtask

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         int lim;
         lim = ($urandom_range(0, 3) == 0) ? DEPTH - 1 : 15;
         cycle($urandom_range(0, 1), $urandom_range(0, lim), $urandom_range(0, 1), $urandom_range(0, lim), $urandom_range(0, 1));
      end
   endtask

   initial begin
      int v;
      #2;
      do_reset();
      repeat (DEPTH) cycle(1, $urandom_range(0, DEPTH - 1), 0, 0, 0);
      check("ready_after_sweep", ready, 1);
      cycle(1, 'h3FF, 0, 0, 0);
      check("lookup_3ff", hist_out, 'h000);
      cycle(0, 0, 1, 5, 1);
      cycle(0, 0, 1, 5, 1);
      cycle(0, 0, 1, 5, 0);
      cycle(0, 0, 1, 5, 1);
      cycle(1, 5, 0, 0, 0);
      check("pc5_valid", hist_valid, 1);
      check("pc5_hist", hist_out, 'h00D);
      cycle(0, 5, 0, 0, 0);
      check("idle_hold", hist_out, 'h00D);
      cycle(0, 0, 1, 7, 1);
      cycle(1, 7, 1, 7, 1);
      check("bypass_pc7", hist_out, 'h003);
      cycle(1, 8, 1, 7, 1);
      check("independent_pc8", hist_out, 'h000);
      cycle(1, 7, 0, 0, 0);
      check("pc7_after", hist_out, 'h007);
      repeat (11) cycle(0, 0, 1, 2, 1);
      cycle(1, 2, 0, 0, 0);
      check("pc2_all_ones", hist_out, 'h3FF);
      cycle(0, 0, 1, 2, 0);
      cycle(1, 2, 0, 0, 0);
      check("pc2_shift_out", hist_out, 'h3FE);
      rand_cycles(2000);
      v = 'h155;
      for (int b = 9; b >= 0; b--) cycle(0, 0, 1, 3, v[b]);
      cycle(1, 3, 0, 0, 0);
      check("pc3_set", hist_out, 'h155);
      do_reset();
      cycle(0, 0, 1, 4, 1);
      rand_cycles(DEPTH - 1);
      cycle(1, 3, 0, 0, 0);
      check("pc3_cleared", hist_out, 'h000);
      cycle(1, 4, 0, 0, 0);
      check("pc4_init_drop", hist_out, 'h000);
      rand_cycles(1000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/local_history_table.md
Name: local_history_table

Overview:
- Upstream stage of the local predictor in the tournament branch predictor.
- Holds one per-branch outcome history register per entry, indexed by low PC bits.
- On each prediction request it supplies the indexed history. The history is the index into the 2-bit saturating counter table.
- On branch resolution it shifts the actual outcome into that entry.
- Includes a post-reset clearing sweep and same-cycle read/write bypass.

Parameters:
- PC_IDX_W, 10, number of PC index bits; table depth DEPTH = 2**PC_IDX_W (1024).
- HIST_W, 10, width of each local history entry. Must be at least 2.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- ready  output  1  high when the table is initialised and accepting requests.
- pred_valid  input  1  prediction lookup request this cycle.
- pred_pc  input  PC_IDX_W  index of the branch being predicted.
- hist_valid  output  1  hist_out carries a valid lookup result this cycle.
- hist_out  output  HIST_W  local history for the prior cycle's pred_pc.
- upd_valid  input  1  resolved-branch update this cycle.
- upd_pc  input  PC_IDX_W  index of the resolved branch.
- upd_taken  input  1  actual outcome (1 = taken), shifted into history.

Behaviour:
- Reset, asynchronous, while reset_n = 0:
  - state = INIT, init_ptr = 0, ready = 0, hist_valid = 0, hist_out = 0.
  - Table contents are not touched asynchronously.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle write 0 to table[init_ptr], then init_ptr++.
  - The cycle that writes entry DEPTH-1 moves state to RUN.
  - ready = 1 from the first RUN cycle, i.e. DEPTH cycles after reset release.
  - pred_valid and upd_valid are ignored and dropped in INIT: no table write from the update port, and hist_valid stays 0.
- RUN, lookup:
  - If pred_valid, then next cycle hist_valid = 1 and hist_out = table[pred_pc] (1-cycle registered latency).
  - If pred_valid = 0, next cycle hist_valid = 0 and hist_out holds its previous value.
- RUN, update:
  - If upd_valid, table[upd_pc] <= {table[upd_pc][HIST_W-2:0], upd_taken}.
  - The newest outcome goes into the LSB and the oldest bit (MSB) is discarded.
  - The write is visible to a lookup issued in the following cycle.
- Bypass: same cycle pred_valid and upd_valid with pred_pc == upd_pc gives hist_out = post-update value, i.e. {old[HIST_W-2:0], upd_taken}, not the stale entry.
- Lookup and update to different indices in the same cycle are independent; both complete.
- Back-to-back updates to the same index in consecutive cycles accumulate. There is no lost update.
- No saturation: history always shifts. An all-ones entry followed by not-taken becomes all-ones with LSB = 0.
- Reset asserted mid-RUN:
  - Returns immediately to INIT and forces ready/hist_valid/hist_out to 0.
  - After release, the full sweep reruns and all entries read 0.
- X-free: hist_out never reflects an unwritten entry in RUN.

Test Plan:
- Release reset, hold pred_valid = 1 -> ready stays 0 and hist_valid stays 0 for exactly 1024 cycles, then ready = 1. A lookup of pc 0x3FF one cycle later returns hist_out = 0x000.
- Updates to pc 5: taken, taken, not-taken, taken in consecutive cycles, then lookup pc 5 -> hist_out = 0x00D with hist_valid = 1 exactly one cycle after the request.
- Same cycle: pred_pc = upd_pc = 7, entry currently 0x001, upd_taken = 1 -> next cycle hist_out = 0x003 (bypass). The same scenario with pred_pc = 8 returns the unmodified entry 8 value.
- Wrap/shift-out: 11 taken updates to pc 2 -> lookup gives 0x3FF. One not-taken update -> lookup gives 0x3FE.
- Reset mid-RUN:
  - Set pc 3 to 0x155, pulse reset_n low for 2 cycles mid-stream -> ready/hist_valid/hist_out drop to 0 asynchronously.
  - After 1024 init cycles, lookup pc 3 returns 0x000.
- Update during INIT: assert upd_valid on pc 4 with upd_taken = 1 while ready = 0 -> after init, lookup pc 4 returns 0x000.
